// File: rtl/fish_swarm_ctrl.sv
// Fish swarm motion and per-pixel hit query for the VGA fish scene.
// Positions update once per frame in vblank; hit result is registered (latency 1).
module fish_swarm_ctrl #(
  parameter int          NUM_FISH  = 4,
  parameter int          FISH_W    = 10,
  parameter int          FISH_H    = 5,
  parameter int          X_START   = 640,
  parameter int          STAGGER   = 160,
  parameter int          Y0        = 60,
  parameter int          Y_SPACING = 100,
  parameter bit          VSYNC_POL = 1'b1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync,
  input  logic                  display_on,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic                  pause,
  input  logic [1:0]            speed,
  output logic [10*NUM_FISH-1:0] fish_x_flat,
  output logic [10*NUM_FISH-1:0] fish_y_flat,
  output logic                  busy,
  output logic                  fish_on,
  output logic [2:0]            fish_id,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_UPD = 2'd1, S_DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [9:0]  fish_x [NUM_FISH];
  logic [9:0]  fish_y [NUM_FISH];
  logic [15:0] lfsr;
  logic        vsync_d;
  logic        vs_act;
  logic        frame_edge;
  logic [2:0]  step;
  logic [8:0]  rnd;
  logic [9:0]  respawn_y;
  logic        hit_any;
  logic [2:0]  hit_idx;

  assign vs_act     = (vsync == VSYNC_POL);
  assign frame_edge = vs_act & ~vsync_d;
  assign step       = {1'b0, speed} + 3'd1;
  assign rnd        = lfsr[8:0];
  // Values too low on screen fold back up by 256 so the fish stays visible.
  assign respawn_y  = (rnd > 9'(480 - FISH_H)) ? {1'b0, rnd - 9'd256} : {1'b0, rnd};
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (frame_edge) begin
          state_nxt = S_UPD;
          idx_nxt   = 3'd0;
        end
      end
      S_UPD: begin
        idx_nxt = idx + 3'd1;
        if (idx == 3'(NUM_FISH - 1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= 3'd0;
      vsync_d <= 1'b0;
      lfsr    <= LFSR_SEED;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      vsync_d <= vs_act;
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FISH; i++) begin
        fish_x[i] <= 10'(X_START - i * STAGGER);
        fish_y[i] <= 10'(Y0 + i * Y_SPACING);
      end
    end else if (state == S_UPD && !pause) begin
      for (int i = 0; i < NUM_FISH; i++) begin
        if (idx == 3'(i)) begin
          if (fish_x[i] > {7'd0, step}) begin
            fish_x[i] <= fish_x[i] - {7'd0, step};
          end else begin
            fish_x[i] <= 10'(X_START);
            fish_y[i] <= respawn_y;
          end
        end
      end
    end
  end

  // Scan high to low so the lowest hitting index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = 3'd0;
    for (int i = NUM_FISH - 1; i >= 0; i--) begin
      if ({1'b0, hpos} >= {1'b0, fish_x[i]} &&
          {1'b0, hpos} <  {1'b0, fish_x[i]} + 11'(FISH_W) &&
          {1'b0, vpos} >= {1'b0, fish_y[i]} &&
          {1'b0, vpos} <  {1'b0, fish_y[i]} + 11'(FISH_H)) begin
        hit_any = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fish_on <= 1'b0;
      fish_id <= 3'd0;
    end else begin
      fish_on <= display_on & hit_any;
      fish_id <= hit_idx;
    end
  end

  for (genvar g = 0; g < NUM_FISH; g++) begin : g_flat
    assign fish_x_flat[10*g +: 10] = fish_x[g];
    assign fish_y_flat[10*g +: 10] = fish_y[g];
  end

endmodule

// File: tb/tb_fish_swarm_ctrl.sv
// Directed bench for fish_swarm_ctrl: reset, motion, overrun, pause, respawn,
// mid-update reset and the registered hit query including overlap priority.
module tb_fish_swarm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, vsync, display_on, pause;
  logic [9:0]  hpos, vpos;
  logic [1:0]  speed;
  logic [39:0] fish_x_flat, fish_y_flat;
  logic        busy, fish_on;
  logic [2:0]  fish_id;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] lfsr_m;
  logic [9:0]  mx [4];
  logic [9:0]  my [4];

  localparam logic [39:0] RST_X = {10'd160, 10'd320, 10'd480, 10'd640};
  localparam logic [39:0] RST_Y = {10'd360, 10'd260, 10'd160, 10'd60};

  fish_swarm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .display_on(display_on),
    .hpos(hpos), .vpos(vpos), .pause(pause), .speed(speed),
    .fish_x_flat(fish_x_flat), .fish_y_flat(fish_y_flat), .busy(busy),
    .fish_on(fish_on), .fish_id(fish_id), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [9:0] y_of(input logic [8:0] r);
    return (r > 9'd475) ? {1'b0, r - 9'd256} : {1'b0, r};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= lfsr_nx(lfsr_m);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 10'(640 - i * 160);
      my[i] = 10'(60 + i * 100);
    end
  endtask

  function automatic logic [39:0] flat_of(input logic is_y);
    logic [39:0] f;
    for (int i = 0; i < 4; i++) f[10*i +: 10] = is_y ? my[i] : mx[i];
    return f;
  endfunction

  // One frame: pause is driven per fish slot from pm; optional second vsync edge while busy.
  task automatic do_frame(input logic [3:0] pm, input logic [1:0] spd, input logic overrun);
    int          nb;
    logic [15:0] lf;
    logic [2:0]  st;
    speed = spd;
    vsync = 1'b1;
    tick();
    nb = 0;
    for (int j = 0; j < 4; j++) begin
      if (busy) nb++;
      lf    = lfsr_m;
      pause = pm[j];
      if (overrun && j == 1) vsync = 1'b0;
      if (overrun && j == 2) vsync = 1'b1;
      tick();
      st = {1'b0, spd} + 3'd1;
      if (!pm[j]) begin
        if (mx[j] > {7'd0, st}) mx[j] = mx[j] - {7'd0, st};
        else begin
          mx[j] = 10'd640;
          my[j] = y_of(lf[8:0]);
        end
      end
    end
    vsync = 1'b0;
    pause = 1'b0;
    for (int t = 0; t < 10 && busy; t++) begin
      nb++;
      tick();
    end
    chk("busy_cycles", 40'(nb), 40'd5);
  endtask

  task automatic hit(input string tag, input logic de, input logic [9:0] hp,
                     input logic [9:0] vp, input logic on_e, input logic [2:0] id_e);
    display_on = de;
    hpos = hp;
    vpos = vp;
    tick();
    chk({tag, "_on"}, 40'(fish_on), 40'(on_e));
    chk({tag, "_id"}, 40'(fish_id), 40'(id_e));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          nf;
    int          d;
    logic [15:0] v;
    logic [9:0]  yc;

    rst_n = 1'b0; vsync = 1'b0; display_on = 1'b0; pause = 1'b0;
    hpos = 10'd0; vpos = 10'd0; speed = 2'd0;
    model_reset();
    tick();
    tick();
    chk("rst_x", fish_x_flat, RST_X);
    chk("rst_y", fish_y_flat, RST_Y);
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_on", 40'(fish_on), 40'd0);
    chk("rst_id", 40'(fish_id), 40'd0);
    chk("rst_state", 40'(dbg_state), 40'd0);
    rst_n = 1'b1;
    tick();

    // hit query around fish 2 at (320,260)
    for (int vp = 260; vp < 265; vp++)
      for (int hp = 320; hp < 330; hp++)
        hit("in_f2", 1'b1, 10'(hp), 10'(vp), 1'b1, 3'd2);
    hit("right_edge", 1'b1, 10'd330, 10'd262, 1'b0, 3'd0);
    hit("left_edge", 1'b1, 10'd319, 10'd262, 1'b0, 3'd0);
    hit("bottom_edge", 1'b1, 10'd325, 10'd265, 1'b0, 3'd0);
    hit("f1_in", 1'b1, 10'd485, 10'd162, 1'b1, 3'd1);
    hit("blank", 1'b0, 10'd325, 10'd262, 1'b0, 3'd2);
    display_on = 1'b0;

    do_frame(4'b0000, 2'd0, 1'b0);
    chk("f1_x", fish_x_flat, {10'd159, 10'd319, 10'd479, 10'd639});
    chk("f1_y", fish_y_flat, RST_Y);

    do_frame(4'b0000, 2'd0, 1'b1);
    chk("ovr_x", fish_x_flat, {10'd158, 10'd318, 10'd478, 10'd638});
    tick();
    tick();
    chk("ovr_quiet", 40'(busy), 40'd0);

    for (int k = 0; k < 3; k++) do_frame(4'b1111, 2'd0, 1'b0);
    chk("pause_x", fish_x_flat, {10'd158, 10'd318, 10'd478, 10'd638});
    chk("pause_y", fish_y_flat, RST_Y);

    nf = 0;
    while (mx[3] > 10'd4 && nf < 60) begin
      do_frame(4'b0000, 2'd3, 1'b0);
      nf++;
    end
    chk("pre_resp_frames", 40'(nf), 40'd39);
    chk("pre_resp_x3", 40'(fish_x_flat[39:30]), 40'd2);
    do_frame(4'b0000, 2'd3, 1'b0);
    chk("resp_x3", 40'(fish_x_flat[39:30]), 40'd640);
    chk("resp_y3", 40'(fish_y_flat[39:30]), 40'(my[3]));
    chk("resp_x_all", fish_x_flat, flat_of(1'b0));
    chk("resp_y_all", fish_y_flat, flat_of(1'b1));

    // reset while fish 2 is being updated
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    tick();
    chk("mid_state", 40'(dbg_state), 40'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_x", fish_x_flat, RST_X);
    chk("mid_rst_y", fish_y_flat, RST_Y);
    chk("mid_rst_busy", 40'(busy), 40'd0);
    chk("mid_rst_state", 40'(dbg_state), 40'd0);
    rst_n = 1'b1;
    model_reset();
    tick();

    // overlap: respawn fish 2 at a height overlapping fish 1, then slide it onto fish 1
    nf = 0;
    while (mx[2] > 10'd4 && nf < 100) begin
      do_frame(4'b1011, 2'd3, 1'b0);
      nf++;
    end
    chk("f2_walk_x", 40'(fish_x_flat[29:20]), 40'd4);
    v = lfsr_m;
    v = lfsr_nx(lfsr_nx(lfsr_nx(v)));
    d = 0;
    yc = y_of(v[8:0]);
    while (!(yc >= 10'd156 && yc <= 10'd164) && d < 8000) begin
      v = lfsr_nx(v);
      d++;
      yc = y_of(v[8:0]);
    end
    chk("seed_search", 40'(d < 8000), 40'd1);
    for (int t = 0; t < d; t++) tick();
    do_frame(4'b1011, 2'd3, 1'b0);
    chk("f2_resp_x", 40'(fish_x_flat[29:20]), 40'd640);
    chk("f2_resp_y", 40'(fish_y_flat[29:20]), 40'(yc));
    nf = 0;
    while (mx[2] > 10'd484 && nf < 60) begin
      do_frame(4'b1011, 2'd3, 1'b0);
      nf++;
    end
    chk("f2_slide_x", 40'(fish_x_flat[29:20]), 40'd484);
    chk("f1_fixed_x", 40'(fish_x_flat[19:10]), 40'd480);
    hit("overlap", 1'b1, 10'd484, (yc > 10'd160) ? yc : 10'd160, 1'b1, 3'd1);
    hit("f2_only", 1'b1, 10'd491, yc, 1'b1, 3'd2);
    hit("f1_only", 1'b1, 10'd481, (yc > 10'd160) ? 10'd160 : 10'd164, 1'b1, 3'd1);
    display_on = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
